// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and types for the write arbiter slice.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    // Bit positions inside the 2-bit RegWrite bus
    localparam int RW_WE    = 1;
    localparam int RW_SRC_Q = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    // Build a register write-enable bus from its two flags
    function automatic logic [1:0] make_regwrite(input logic we, input logic src_q);
        logic [1:0] v;
        v           = 2'b00;
        v[RW_WE]    = we;
        v[RW_SRC_Q] = src_q;
        return v;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_result_fifo.sv
// Long-latency result queue: {rd, data, live} FIFO with per-entry
// destination compare so a younger pipeline write can kill stale results.
module wb_result_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  reg_addr_t push_rd_i,
    input  reg_data_t push_data_i,
    input  logic      push_live_i,
    input  logic      pop_i,
    input  logic      kill_i,
    input  reg_addr_t kill_rd_i,
    output logic      full_o,
    output logic      empty_o,
    output reg_addr_t head_rd_o,
    output reg_data_t head_data_o,
    output logic      head_live_o,
    output logic      kill_hit_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    reg_addr_t          r_rd   [DEPTH];
    reg_data_t          r_data [DEPTH];
    logic [DEPTH-1:0]   r_live;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_push_kill;
    logic [DEPTH-1:0]   w_kill_vec;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == {CNT_W{1'b0}});
    assign w_pop       = pop_i & ~w_empty;
    // A pop frees a slot, so a push is legal when full if a pop happens too
    assign w_push      = push_i & (~w_full | w_pop);
    assign w_push_kill = kill_i & (push_rd_i == kill_rd_i);

    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign head_rd_o   = r_rd[r_rd_ptr];
    assign head_data_o = r_data[r_rd_ptr];
    assign head_live_o = r_live[r_rd_ptr];
    assign kill_hit_o  = (|w_kill_vec) | (w_push & push_live_i & w_push_kill);

    // Find occupied live entries whose destination matches the kill address
    always_comb begin
        logic [PTR_W-1:0] v_off;
        w_kill_vec = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            v_off = PTR_W'(i) - r_rd_ptr;
            if (({1'b0, v_off} < r_count) && r_live[i] && (r_rd[i] == kill_rd_i)) begin
                w_kill_vec[i] = kill_i;
            end else begin
                w_kill_vec[i] = 1'b0;
            end
        end
    end

    // Storage, pointers and occupancy count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_live   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= {REG_ADDR_W{1'b0}};
                r_data[i] <= {REG_DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill_vec[i]) begin
                    r_live[i] <= 1'b0;
                end
            end
            // The entry entering this cycle is also subject to the kill
            if (w_push) begin
                r_rd[r_wr_ptr]   <= push_rd_i;
                r_data[r_wr_ptr] <= push_data_i;
                r_live[r_wr_ptr] <= push_live_i & ~w_push_kill;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter for the register file: pipeline writeback has
// priority, long-latency results drain from a queue, and a pending-write
// scoreboard lets decode stall on outstanding long-latency destinations.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pipe_valid_i,
    input  logic                 pipe_regwrite_i,
    input  logic [4:0]           pipe_rd_i,
    input  logic [31:0]          pipe_data_i,
    input  logic                 issue_valid_i,
    input  logic [4:0]           issue_rd_i,
    input  logic                 lu_valid_i,
    input  logic [4:0]           lu_rd_i,
    input  logic [31:0]          lu_data_i,
    output logic                 lu_ready_o,
    output logic [4:0]           RDaddr_o,
    output logic [31:0]          RDdata_o,
    output logic [1:0]           RegWrite_o,
    output logic [NUM_REGS-1:0]  busy_o
);

    logic                w_pipe_req;
    logic                w_lu_ready;
    logic                w_lu_fire;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    reg_addr_t           w_head_rd;
    reg_data_t           w_head_data;
    logic                w_head_live;
    logic                w_kill_hit;
    logic [NUM_REGS-1:0] w_busy_nxt;

    reg_addr_t           r_rd_addr;
    reg_data_t           r_rd_data;
    logic [1:0]          r_reg_write;
    logic [NUM_REGS-1:0] r_busy;

    assign w_pipe_req = pipe_valid_i & pipe_regwrite_i & (pipe_rd_i != 5'd0);
    assign w_lu_ready = ~w_full;
    assign w_lu_fire  = lu_valid_i & w_lu_ready;
    // The queue only drains on cycles the pipeline leaves the port free
    assign w_pop      = ~w_pipe_req & ~w_empty;

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_lu_fire),
        .push_rd_i   (lu_rd_i),
        .push_data_i (lu_data_i),
        .push_live_i (lu_rd_i != 5'd0),
        .pop_i       (w_pop),
        .kill_i      (w_pipe_req),
        .kill_rd_i   (pipe_rd_i),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .head_rd_o   (w_head_rd),
        .head_data_o (w_head_data),
        .head_live_o (w_head_live),
        .kill_hit_o  (w_kill_hit)
    );

    // Scoreboard next state: clears first, then the issue set overrides
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop && w_head_live) begin
            w_busy_nxt[w_head_rd] = 1'b0;
        end else if (w_pipe_req && w_kill_hit) begin
            w_busy_nxt[pipe_rd_i] = 1'b0;
        end else begin
            w_busy_nxt = r_busy;
        end
        if (issue_valid_i && (issue_rd_i != 5'd0)) begin
            w_busy_nxt[issue_rd_i] = 1'b1;
        end else begin
            w_busy_nxt[0] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Registered write port and scoreboard
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_addr   <= {REG_ADDR_W{1'b0}};
            r_rd_data   <= {REG_DATA_W{1'b0}};
            r_reg_write <= 2'b00;
            r_busy      <= {NUM_REGS{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
            if (w_pipe_req) begin
                r_rd_addr   <= pipe_rd_i;
                r_rd_data   <= pipe_data_i;
                r_reg_write <= make_regwrite(1'b1, 1'b0);
            end else if (w_pop && w_head_live) begin
                r_rd_addr   <= w_head_rd;
                r_rd_data   <= w_head_data;
                r_reg_write <= make_regwrite(1'b1, 1'b1);
            end else begin
                r_reg_write <= 2'b00;
            end
        end
    end

    assign lu_ready_o = w_lu_ready;
    assign RDaddr_o   = r_rd_addr;
    assign RDdata_o   = r_rd_data;
    assign RegWrite_o = r_reg_write;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: expected writes are queued
// when stimulus is driven and popped when the DUT drives RegWrite_o.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        pipe_valid_i, pipe_regwrite_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        lu_valid_i;
    logic [4:0]  lu_rd_i;
    logic [31:0] lu_data_i;
    logic        lu_ready_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic [1:0]  RegWrite_o;
    logic [31:0] busy_o;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t pipe_exp[$];
    wr_t lu_exp[$];
    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;
    bit  prev_rst = 1'b0;
    bit  prev_pipe = 1'b0;

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .pipe_valid_i    (pipe_valid_i),
        .pipe_regwrite_i (pipe_regwrite_i),
        .pipe_rd_i       (pipe_rd_i),
        .pipe_data_i     (pipe_data_i),
        .issue_valid_i   (issue_valid_i),
        .issue_rd_i      (issue_rd_i),
        .lu_valid_i      (lu_valid_i),
        .lu_rd_i         (lu_rd_i),
        .lu_data_i       (lu_data_i),
        .lu_ready_o      (lu_ready_o),
        .RDaddr_o        (RDaddr_o),
        .RDdata_o        (RDdata_o),
        .RegWrite_o      (RegWrite_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_valid_i    = 1'b0;
        pipe_regwrite_i = 1'b0;
        pipe_rd_i       = 5'd0;
        pipe_data_i     = 32'd0;
        issue_valid_i   = 1'b0;
        issue_rd_i      = 5'd0;
        lu_valid_i      = 1'b0;
        lu_rd_i         = 5'd0;
        lu_data_i       = 32'd0;
    endtask

    task automatic pipe_wr(input logic [4:0] rd, input logic [31:0] data);
        pipe_valid_i    = 1'b1;
        pipe_regwrite_i = 1'b1;
        pipe_rd_i       = rd;
        pipe_data_i     = data;
    endtask

    task automatic lu_offer(input logic [4:0] rd, input logic [31:0] data);
        lu_valid_i = 1'b1;
        lu_rd_i    = rd;
        lu_data_i  = data;
    endtask

    // Output checker then reference-model update, once per cycle mid-period
    always @(negedge clk) begin
        wr_t e;
        if (mon_en) begin
            if (prev_rst) begin
                check_eq("post_rst_nowrite", RegWrite_o, 32'd0);
            end else if (prev_pipe) begin
                e = pipe_exp.pop_front();
                check_eq("pipe_we", RegWrite_o, 32'd2);
                check_eq("pipe_addr", RDaddr_o, e.rd);
                check_eq("pipe_data", RDdata_o, e.data);
            end else if (RegWrite_o[1]) begin
                check_eq("q_write_expected", lu_exp.size() != 0, 32'd1);
                if (lu_exp.size() != 0) begin
                    e = lu_exp.pop_front();
                    check_eq("q_we", RegWrite_o, 32'd3);
                    check_eq("q_addr", RDaddr_o, e.rd);
                    check_eq("q_data", RDdata_o, e.data);
                end
            end
        end
        prev_rst  = rst_i;
        prev_pipe = 1'b0;
        if (rst_i) begin
            lu_exp.delete();
            pipe_exp.delete();
            mon_en = 1'b1;
        end else begin
            if (lu_valid_i && lu_ready_o && lu_rd_i != 5'd0)
                lu_exp.push_back('{lu_rd_i, lu_data_i});
            if (pipe_valid_i && pipe_regwrite_i && pipe_rd_i != 5'd0) begin
                pipe_exp.push_back('{pipe_rd_i, pipe_data_i});
                prev_pipe = 1'b1;
                for (int i = lu_exp.size() - 1; i >= 0; i--)
                    if (lu_exp[i].rd == pipe_rd_i) lu_exp.delete(i);
            end
        end
    end

    initial begin
        int idx;
        bit fired;
        idle();
        rst_i = 1'b1;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_lu_ready", lu_ready_o, 32'd1);
        check_eq("rst_regwrite", RegWrite_o, 32'd0);
        check_eq("rst_busy", busy_o, 32'd0);
        check_eq("rst_addr", RDaddr_o, 32'd0);
        check_eq("rst_data", RDdata_o, 32'd0);
        tick();
        rst_i = 1'b0;

        // Direct pipe write appears one cycle later
        pipe_wr(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        @(negedge clk);
        check_eq("t1_addr", RDaddr_o, 32'd5);
        check_eq("t1_data", RDdata_o, 32'hDEADBEEF);
        check_eq("t1_we", RegWrite_o, 32'd2);
        tick();

        // Queue drain with scoreboard tracking
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd7;
        tick();
        idle();
        @(negedge clk);
        check_eq("t2_busy_set", busy_o[7], 32'd1);
        tick();
        lu_offer(5'd7, 32'h1234);
        @(negedge clk);
        check_eq("t2_ready", lu_ready_o, 32'd1);
        tick();
        idle();
        @(negedge clk);
        check_eq("t2_not_yet", RegWrite_o[1], 32'd0);
        check_eq("t2_busy_held", busy_o[7], 32'd1);
        tick();
        @(negedge clk);
        check_eq("t2_we", RegWrite_o, 32'd3);
        check_eq("t2_addr", RDaddr_o, 32'd7);
        check_eq("t2_data", RDdata_o, 32'h1234);
        tick();
        @(negedge clk);
        check_eq("t2_busy_clr", busy_o[7], 32'd0);
        tick();

        // Priority and backpressure
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c < 5) pipe_wr(5'(1 + c), 32'h5000 + 32'(c));
            if (idx < 3) lu_offer(5'(10 + idx), 32'hC000 + 32'(idx));
            if (c == 2) check_eq("t3_ready_full", lu_ready_o, 32'd0);
            fired = lu_valid_i && lu_ready_o;
            tick();
            if (fired) idx++;
        end
        idle();
        check_eq("t3_all_accepted", idx, 32'd3);
        repeat (3) tick();
        check_eq("t3_drained", lu_exp.size(), 32'd0);

        // WAW kill by younger pipe write
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd9;
        lu_offer(5'd9, 32'hAAAA);
        pipe_wr(5'd3, 32'h3333);
        tick();
        idle();
        pipe_wr(5'd9, 32'hBBBB);
        tick();
        idle();
        @(negedge clk);
        check_eq("t4_data", RDdata_o, 32'hBBBB);
        check_eq("t4_busy_clr", busy_o[9], 32'd0);
        tick();
        @(negedge clk);
        check_eq("t4_no_qwrite", RegWrite_o[1], 32'd0);
        check_eq("t4_busy_still_clr", busy_o[9], 32'd0);
        repeat (2) tick();

        // Register zero is never written or marked busy
        pipe_wr(5'd0, 32'h0F0F);
        lu_offer(5'd0, 32'hF0F0);
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd0;
        tick();
        idle();
        @(negedge clk);
        check_eq("t5_pipe_r0", RegWrite_o[1], 32'd0);
        check_eq("t5_busy0", busy_o[0], 32'd0);
        tick();
        @(negedge clk);
        check_eq("t5_lu_r0", RegWrite_o[1], 32'd0);
        tick();

        // Mid-operation reset flushes queue and scoreboard
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd20;
        tick();
        idle();
        issue_valid_i = 1'b1;
        issue_rd_i    = 5'd21;
        pipe_wr(5'd1, 32'h1111);
        lu_offer(5'd20, 32'hD020);
        tick();
        idle();
        pipe_wr(5'd2, 32'h2222);
        lu_offer(5'd21, 32'hD021);
        tick();
        idle();
        pipe_wr(5'd3, 32'h3333);
        @(negedge clk);
        check_eq("t6_busy20", busy_o[20], 32'd1);
        check_eq("t6_busy21", busy_o[21], 32'd1);
        check_eq("t6_full", lu_ready_o, 32'd0);
        tick();
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check_eq("t6_busy_flushed", busy_o, 32'd0);
        check_eq("t6_ready", lu_ready_o, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check_eq("t6_no_write", RegWrite_o, 32'd0);
        end

        tick();
        check_eq("end_pipe_q", pipe_exp.size(), 32'd0);
        check_eq("end_lu_q", lu_exp.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
